serial_operand_recover: RTL and testbench

Bit-serial inverse of the combinational addition block: given a sum and one known operand, it recovers the other operand, `op2 = sum - op1`, modulo 2^WIDTH. It also flags underflow (`sum < op1`), so the checker can confirm that an addition result is consistent. It sits between the addition results bus and the verification scoreboard, uses a valid/ready handshake on both sides, and processes one bit per cycle, LSB first, to keep area minimal.

---
 rtl/operand_recover_pkg.sv | 12 +
 rtl/borrow_cell.sv | 13 +
 rtl/serial_operand_recover.sv | 119 +++++++++++
 tb/tb_serial_operand_recover.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/operand_recover_pkg.sv
// Shared types and constants for the bit-serial operand recovery block.
package operand_recover_pkg;

  localparam int REC_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rec_state_t;

endpackage

// File: rtl/borrow_cell.sv
// One-bit full subtractor: computes s - a - bin with difference and borrow out.
module borrow_cell (
  input  logic s,
  input  logic a,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = s ^ a ^ bin;
  assign bout = (~s & a) | (~(s ^ a) & bin);

endmodule

// File: rtl/serial_operand_recover.sv
// Recovers op2 = sum - op1 (mod 2^WIDTH) one bit per cycle, LSB first,
// with a final borrow flag; valid/ready handshake on input and output.
module serial_operand_recover
  import operand_recover_pkg::*;
#(
  parameter int WIDTH = REC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] op1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] op2,
  output logic             underflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  rec_state_t       state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic             b_q, b_d;
  logic             uf_q, uf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_bit;
  logic             bout_bit;

  borrow_cell u_cell (
    .s    (s_q[0]),
    .a    (a_q[0]),
    .bin  (b_q),
    .d    (d_bit),
    .bout (bout_bit)
  );

  // Next-state and datapath update for the serial subtraction
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    a_d     = a_q;
    r_d     = r_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    op2_d   = op2_q;
    uf_d    = uf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = sum;
          a_d     = op1;
          b_d     = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        s_d = {1'b0, s_q[WIDTH-1:1]};
        a_d = {1'b0, a_q[WIDTH-1:1]};
        r_d = {d_bit, r_q[WIDTH-1:1]};
        b_d = bout_bit;
        // Outputs are captured separately so op2 stays put while R shifts
        if (cnt_q == CNT_LAST) begin
          op2_d   = {d_bit, r_q[WIDTH-1:1]};
          uf_d    = bout_bit;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shift registers, borrow flop, counter and captured result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      a_q     <= '0;
      r_q     <= '0;
      b_q     <= 1'b0;
      cnt_q   <= '0;
      op2_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      a_q     <= a_d;
      r_q     <= r_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      op2_q   <= op2_d;
      uf_q    <= uf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign op2       = op2_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_serial_operand_recover.sv
// Directed self-checking bench for serial_operand_recover at WIDTH 8 and 4.
module tb_serial_operand_recover;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0] sum8 = 8'h00, op1_8 = 8'h00;
  logic       in_ready8, out_valid8, uf8;
  logic [7:0] op2_8;

  logic       in_valid4 = 1'b0, out_ready4 = 1'b1;
  logic [3:0] sum4 = 4'h0, op1_4 = 4'h0;
  logic       in_ready4, out_valid4, uf4;
  logic [3:0] op2_4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  serial_operand_recover #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .sum(sum8), .op1(op1_8), .out_valid(out_valid8), .out_ready(out_ready8),
    .op2(op2_8), .underflow(uf8)
  );

  serial_operand_recover #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .sum(sum4), .op1(op1_4), .out_valid(out_valid4), .out_ready(out_ready4),
    .op2(op2_4), .underflow(uf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair to dut8, accept it, and count edges until out_valid.
  task automatic start8(input logic [7:0] s, input logic [7:0] a, output int lat);
    sum8 = s; op1_8 = a; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready8); end
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid8); end
    total++; if (op2_8 !== 8'h00 || uf8 !== 1'b0) begin bad++; $display("FAIL reset_outputs got=%h/%b exp=00/0", op2_8, uf8); end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    out_ready8 = 1'b1;
    start8(8'h5A, 8'h23, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    total++; if (op2_8 !== 8'h37 || uf8 !== 1'b0) begin bad++; $display("FAIL basic_result got=%h/%b exp=37/0", op2_8, uf8); end
    total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL basic_excl got in_ready=%b exp=0", in_ready8); end
    tick();
    total++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin bad++; $display("FAIL basic_return got=%b/%b exp=1/0", in_ready8, out_valid8); end
  endtask

  task automatic test_underflow();
    int lat;
    start8(8'h00, 8'h01, lat);
    total++; if (op2_8 !== 8'hFF || uf8 !== 1'b1) begin bad++; $display("FAIL uf_0_minus_1 got=%h/%b exp=ff/1", op2_8, uf8); end
    tick();
    start8(8'hFF, 8'hFF, lat);
    total++; if (op2_8 !== 8'h00 || uf8 !== 1'b0) begin bad++; $display("FAIL uf_ff_minus_ff got=%h/%b exp=00/0", op2_8, uf8); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready8 = 1'b0;
    start8(8'h10, 8'h0F, lat);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid8 !== 1'b1 || op2_8 !== 8'h01 || uf8 !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/01/0", i, out_valid8, op2_8, uf8);
      end
      tick();
    end
    out_ready8 = 1'b1;
    tick();
    total++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin bad++; $display("FAIL bp_one_handshake got=%b/%b exp=0/1", out_valid8, in_ready8); end
    tick();
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL bp_stays_idle got=%b exp=1", in_ready8); end
  endtask

  task automatic test_busy_reject();
    int extra = 0;
    sum8 = 8'h80; op1_8 = 8'h01; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    sum8 = 8'hAA; op1_8 = 8'h11; in_valid8 = 1'b1;
    total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL busy_in_ready got=%b exp=0", in_ready8); end
    tick();
    in_valid8 = 1'b0;
    for (int i = 0; i < 40 && !out_valid8; i++) tick();
    total++; if (op2_8 !== 8'h7F || uf8 !== 1'b0) begin bad++; $display("FAIL busy_result got=%h/%b exp=7f/0", op2_8, uf8); end
    tick();
    for (int i = 0; i < 15; i++) begin
      if (out_valid8) extra++;
      tick();
    end
    total++; if (extra !== 0 || op2_8 !== 8'h7F) begin bad++; $display("FAIL busy_no_second got=%0d/%h exp=0/7f", extra, op2_8); end
  endtask

  task automatic test_reset_mid();
    int lat;
    sum8 = 8'h5A; op1_8 = 8'h23; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    total++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin bad++; $display("FAIL rstmid_flags got=%b/%b exp=1/0", in_ready8, out_valid8); end
    total++; if (op2_8 !== 8'h00 || uf8 !== 1'b0) begin bad++; $display("FAIL rstmid_outputs got=%h/%b exp=00/0", op2_8, uf8); end
    @(negedge clk); rst = 1'b0;
    tick();
    start8(8'h05, 8'h03, lat);
    total++; if (op2_8 !== 8'h02 || uf8 !== 1'b0 || lat !== 8) begin bad++; $display("FAIL rstmid_after got=%h/%b/%0d exp=02/0/8", op2_8, uf8, lat); end
    tick();
  endtask

  task automatic test_width4();
    int lat = 0;
    sum4 = 4'h3; op1_4 = 4'h5; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    while (!out_valid4 && lat < 40) begin tick(); lat++; end
    total++; if (lat !== 4) begin bad++; $display("FAIL w4_latency got=%0d exp=4", lat); end
    total++; if (op2_4 !== 4'hE || uf4 !== 1'b1) begin bad++; $display("FAIL w4_result got=%h/%b exp=e/1", op2_4, uf4); end
    tick();
  endtask

  task automatic test_back_to_back();
    int rise [$];
    logic prev = 1'b0;
    sum8 = 8'h33; op1_8 = 8'h11; out_ready8 = 1'b1; in_valid8 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid8 && !prev) rise.push_back(cyc);
      prev = out_valid8;
    end
    in_valid8 = 1'b0;
    total++;
    if (rise.size() < 3) begin
      bad++; $display("FAIL b2b_count got=%0d exp>=3", rise.size());
    end else if (rise[1] - rise[0] !== 10 || rise[2] - rise[1] !== 10) begin
      bad++; $display("FAIL b2b_period got=%0d,%0d exp=10", rise[1] - rise[0], rise[2] - rise[1]);
    end
    total++; if (op2_8 !== 8'h22) begin bad++; $display("FAIL b2b_result got=%h exp=22", op2_8); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_backpressure();
    test_busy_reject();
    test_reset_mid();
    test_width4();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
